// File: rtl/sram_port_pkg.sv
// Shared types and helpers for the SRAM port controller.
package sram_port_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        TURN
    } state_t;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ADDR_W      = 20;
    localparam int DEF_WAIT_STATES = 2;
    localparam int MAX_LANES       = 8;

    // Each byte-enable bit becomes eight mask bits over its lane.
    function automatic logic [8*MAX_LANES-1:0] lane_mask(input logic [MAX_LANES-1:0] be);
        logic [8*MAX_LANES-1:0] m;
        for (int i = 0; i < MAX_LANES; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sram_cmd_buf.sv
// One-entry command holding register; only the valid flag is reset.
module sram_cmd_buf
    import sram_port_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LANES  = DEF_DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              pop,
    input  logic              in_we,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [LANES-1:0]  in_be,
    output logic              valid,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_wdata,
    output logic [LANES-1:0]  out_be
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            out_we    <= in_we;
            out_addr  <= in_addr;
            out_wdata <= in_wdata;
            out_be    <= in_be;
        end
    end

endmodule

// File: rtl/sram_port_ctrl.sv
// SLC-3 memory port to asynchronous SRAM: request/ready command port, one-entry
// buffer, programmable wait states, byte lanes and read-to-write turnaround.
module sram_port_ctrl
    import sram_port_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_STATES = DEF_WAIT_STATES,
    localparam int LANES      = DATA_W / 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LANES-1:0]  req_be,
    output logic              req_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              wdone,
    output logic              busy,
    output logic              CE_N,
    output logic              OE_N,
    output logic              WE_N,
    output logic [LANES-1:0]  BE_N,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Data
);

    localparam int CNT_W = $clog2(WAIT_STATES + 1);

    state_t             state, nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic               buf_valid, buf_we;
    logic [ADDR_W-1:0]  buf_addr;
    logic [DATA_W-1:0]  buf_wdata;
    logic [LANES-1:0]   buf_be;

    logic               cur_we;
    logic [ADDR_W-1:0]  cur_addr;
    logic [DATA_W-1:0]  cur_wdata;
    logic [LANES-1:0]   cur_be;

    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [LANES-1:0]   sel_be;

    logic               acc, avail, rd_last, need, take, buf_load, buf_pop;
    logic               nxt_we, act;
    logic [LANES-1:0]   nxt_be;

    logic               ce_n_p1, oe_n_p1, we_n_p1, drv_p1, vld_p1;
    logic [LANES-1:0]   be_n_p1;
    logic [DATA_W-1:0]  rdata_p1;

    logic [MAX_LANES-1:0]   be_ext;
    logic [8*MAX_LANES-1:0] mask_full;
    logic [DATA_W-1:0]      mask;
    logic                   unused_mask;

    assign req_ready = !buf_valid && Reset;
    assign acc       = req && req_ready;
    assign avail     = buf_valid || acc;

    // The buffered command always has priority over a same-cycle request.
    assign sel_we    = buf_valid ? buf_we    : req_we;
    assign sel_addr  = buf_valid ? buf_addr  : req_addr;
    assign sel_wdata = buf_valid ? buf_wdata : req_wdata;
    assign sel_be    = buf_valid ? buf_be    : req_be;

    assign rd_last  = (state == ACCESS) && (cnt == CNT_W'(1)) && !cur_we;
    assign need     = (state == IDLE) || (state == HOLD) || rd_last;
    assign take     = need && avail;
    assign buf_pop  = take && buf_valid;
    assign buf_load = acc && !take;

    sram_cmd_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LANES  (LANES)
    ) u_buf (
        .clk       (Clk),
        .rst_n     (Reset),
        .load      (buf_load),
        .pop       (buf_pop),
        .in_we     (req_we),
        .in_addr   (req_addr),
        .in_wdata  (req_wdata),
        .in_be     (req_be),
        .valid     (buf_valid),
        .out_we    (buf_we),
        .out_addr  (buf_addr),
        .out_wdata (buf_wdata),
        .out_be    (buf_be)
    );

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            IDLE:   if (take) nxt = SETUP;
            SETUP: begin
                nxt     = ACCESS;
                cnt_nxt = CNT_W'(WAIT_STATES);
            end
            ACCESS: begin
                if (cnt != CNT_W'(1)) cnt_nxt = cnt - CNT_W'(1);
                else if (cur_we)      nxt = HOLD;
                else if (take)        nxt = sel_we ? TURN : SETUP;
                else                  nxt = IDLE;
            end
            HOLD:   nxt = take ? SETUP : IDLE;
            TURN:   nxt = SETUP;
            default: nxt = IDLE;
        endcase
    end

    assign nxt_we = take ? sel_we : cur_we;
    assign nxt_be = take ? sel_be : cur_be;
    assign act    = (nxt == SETUP) || (nxt == ACCESS) || (nxt == HOLD);

    always_comb begin
        be_ext              = '0;
        be_ext[LANES-1:0]   = cur_be;
    end
    assign mask_full   = lane_mask(be_ext);
    assign mask        = mask_full[DATA_W-1:0];
    assign unused_mask = ^mask_full;

    // Stage p1: pad strobes and read return registered from the next state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_addr <= '0;
            ce_n_p1  <= 1'b1;
            oe_n_p1  <= 1'b1;
            we_n_p1  <= 1'b1;
            be_n_p1  <= '1;
            drv_p1   <= 1'b0;
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            state    <= nxt;
            cnt      <= cnt_nxt;
            if (take) cur_addr <= sel_addr;
            ce_n_p1  <= ~act;
            oe_n_p1  <= ~(!nxt_we && ((nxt == SETUP) || (nxt == ACCESS)));
            we_n_p1  <= ~(nxt_we && (nxt == ACCESS));
            be_n_p1  <= act ? ~nxt_be : '1;
            drv_p1   <= nxt_we && act;
            vld_p1   <= rd_last;
            if (rd_last) rdata_p1 <= Data & mask;
        end
    end

    always_ff @(posedge Clk) begin
        if (take) begin
            cur_we    <= sel_we;
            cur_wdata <= sel_wdata;
            cur_be    <= sel_be;
        end
    end

    assign CE_N   = ce_n_p1;
    assign OE_N   = oe_n_p1;
    assign WE_N   = we_n_p1;
    assign BE_N   = be_n_p1;
    assign ADDR   = cur_addr;
    assign Data   = drv_p1 ? cur_wdata : {DATA_W{1'bz}};
    assign rdata  = rdata_p1;
    assign rvalid = vld_p1;
    assign wdone  = (state == HOLD);
    assign busy   = (state != IDLE) || buf_valid;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench: 16-bit/W=2 port on a small SRAM model, plus a 32-bit/W=1 port.
module tb_sram_port_ctrl;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic        req = 1'b0, req_we = 1'b0;
    logic [19:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be = '0;
    logic        req_ready, rvalid, wdone, busy, CE_N, OE_N, WE_N;
    logic [15:0] rdata;
    logic [1:0]  BE_N;
    logic [19:0] ADDR;
    wire  [15:0] Data;

    logic        req32 = 1'b0, we32 = 1'b0;
    logic [19:0] addr32 = '0;
    logic [31:0] wdata32 = '0;
    logic [3:0]  be32 = '0;
    logic        req_ready32, rvalid32, wdone32, busy32, CE_N32, OE_N32, WE_N32;
    logic [31:0] rdata32;
    logic [3:0]  BE_N32;
    logic [19:0] ADDR32;
    wire  [31:0] Data32;

    sram_port_ctrl dut (
        .Clk(Clk), .Reset(Reset), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready), .rdata(rdata),
        .rvalid(rvalid), .wdone(wdone), .busy(busy), .CE_N(CE_N), .OE_N(OE_N),
        .WE_N(WE_N), .BE_N(BE_N), .ADDR(ADDR), .Data(Data)
    );

    sram_port_ctrl #(.DATA_W(32), .ADDR_W(20), .WAIT_STATES(1)) dut32 (
        .Clk(Clk), .Reset(Reset), .req(req32), .req_we(we32), .req_addr(addr32),
        .req_wdata(wdata32), .req_be(be32), .req_ready(req_ready32), .rdata(rdata32),
        .rvalid(rvalid32), .wdone(wdone32), .busy(busy32), .CE_N(CE_N32), .OE_N(OE_N32),
        .WE_N(WE_N32), .BE_N(BE_N32), .ADDR(ADDR32), .Data(Data32)
    );

    // SRAM model: drives while selected and output-enabled, writes on WE_N rising.
    logic [15:0] mem [0:255];
    assign Data   = (!CE_N && !OE_N) ? mem[ADDR[7:0]] : 16'hzzzz;
    assign Data32 = (!CE_N32 && !OE_N32) ? {24'hA5B6C7, ADDR32[7:0]} : 32'hzzzz_zzzz;

    always @(posedge WE_N) begin
        if (Reset && !CE_N) begin
            for (int i = 0; i < 2; i++)
                if (!BE_N[i]) mem[ADDR[7:0]][8*i +: 8] = Data[8*i +: 8];
        end
    end

    int bus_viol = 0;
    always @(negedge Clk) begin
        if ((!OE_N && !WE_N) || (!OE_N32 && !WE_N32)) bus_viol++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue16(input logic we, input logic [19:0] a, input logic [15:0] d,
                           input logic [1:0] be, output int lat, output logic [15:0] rd,
                           output int oe_lo);
        @(negedge Clk);
        req = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        lat = -1; rd = '0; oe_lo = 0;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(negedge Clk);
            req = 1'b0;
            if (!OE_N) oe_lo++;
            if ((we && wdone) || (!we && rvalid)) begin
                lat = k;
                rd  = rdata;
            end
        end
        @(negedge Clk);
    endtask

    task automatic issue32(input logic we, input logic [19:0] a, input logic [31:0] d,
                           input logic [3:0] be, output int lat, output logic [31:0] rd,
                           output logic [3:0] ben);
        @(negedge Clk);
        req32 = 1'b1; we32 = we; addr32 = a; wdata32 = d; be32 = be;
        lat = -1; rd = '0; ben = '0;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(negedge Clk);
            req32 = 1'b0;
            if (k == 1) ben = BE_N32;
            if ((we && wdone32) || (!we && rvalid32)) begin
                lat = k;
                rd  = rdata32;
            end
        end
        @(negedge Clk);
    endtask

    int          lat, oe_lo, idx, rv_cnt, wd;
    logic [15:0] rd;
    logic [31:0] rd32;
    logic [3:0]  ben;
    bit          pa;
    int          rv_at [0:2];
    logic [15:0] rv_d  [0:2];
    logic        rdy   [0:4];
    logic [2:0]  exp_str [0:8];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'h1234;
        mem[8'h01] = 16'h1111;
        mem[8'h02] = 16'h2222;
        mem[8'h03] = 16'h3333;
        exp_str = '{3'b001, 3'b001, 3'b001, 3'b111, 3'b011, 3'b010, 3'b010, 3'b011, 3'b111};

        // Reset values
        #2 Reset = 1'b0;
        @(negedge Clk);
        chk("rst_strobes", 32'({CE_N, OE_N, WE_N, BE_N}), 32'h1F);
        chk("rst_addr", 32'(ADDR), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_flags", 32'({rvalid, wdone, busy, req_ready}), 32'h0);
        chk("rst32_strobes", 32'({CE_N32, OE_N32, WE_N32, BE_N32}), 32'h7F);
        chk("rst32_misc", 32'({ADDR32, rdata32[11:0]}), 32'h0);
        chk("rst32_flags", 32'({rvalid32, wdone32, busy32, req_ready32, rdata32[31:12]}), 32'h0);
        Reset = 1'b1;
        @(negedge Clk);
        chk("ready_after_rst", 32'({req_ready, busy}), 32'h2);

        // Single read: latency W+2, OE_N low for SETUP + W ACCESS cycles
        issue16(1'b0, 20'h00010, 16'h0, 2'b11, lat, rd, oe_lo);
        chk("rd_lat", lat, 4);
        chk("rd_data", 32'(rd), 32'h1234);
        chk("rd_oe_cycles", oe_lo, 3);
        issue16(1'b0, 20'h00010, 16'h0, 2'b10, lat, rd, oe_lo);
        chk("rd_lane_mask", 32'(rd), 32'h1200);

        // Byte-lane write then full read
        issue16(1'b1, 20'h00020, 16'hABCD, 2'b01, lat, rd, oe_lo);
        chk("wr_lat", lat, 4);
        issue16(1'b0, 20'h00020, 16'h0, 2'b11, lat, rd, oe_lo);
        chk("wr_lane_readback", 32'(rd), 32'h00CD);

        // Read followed by a buffered write: one TURN cycle between them
        @(negedge Clk);
        req = 1'b1; req_we = 1'b0; req_addr = 20'h00010; req_be = 2'b11;
        for (int k = 1; k <= 9; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                chk("turn_ready_setup", 32'(req_ready), 32'h1);
                req_we = 1'b1; req_addr = 20'h00030; req_wdata = 16'h5A5A;
            end
            if (k == 2) begin
                req = 1'b0;
                chk("turn_busy", 32'({busy, req_ready}), 32'h2);
            end
            chk($sformatf("turn_strobes_c%0d", k), 32'({CE_N, OE_N, WE_N}), 32'(exp_str[k-1]));
            if (k == 4) chk("turn_rvalid", 32'({rvalid, rdata}), 32'h11234);
            if (k == 8) chk("turn_wdone", 32'(wdone), 32'h1);
        end
        issue16(1'b0, 20'h00030, 16'h0, 2'b11, lat, rd, oe_lo);
        chk("turn_write_readback", 32'(rd), 32'h5A5A);

        // Backpressure: req held high across three reads
        idx = 0; rv_cnt = 0; pa = 1'b0;
        @(negedge Clk);
        req = 1'b1; req_we = 1'b0; req_be = 2'b11; req_addr = 20'h00001;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) @(negedge Clk);
            if (pa) begin
                idx++;
                if (idx == 3) req = 1'b0;
                else          req_addr = 20'(idx + 1);
            end
            if (k < 5) rdy[k] = req_ready;
            if (rvalid) begin
                if (rv_cnt < 3) begin
                    rv_at[rv_cnt] = k;
                    rv_d[rv_cnt]  = rdata;
                end
                rv_cnt++;
            end
            pa = req && req_ready;
        end
        chk("bp_ready_pattern", 32'({rdy[0], rdy[1], rdy[2], rdy[3], rdy[4]}), 32'b11001);
        chk("bp_accepted", idx, 3);
        chk("bp_rvalid_count", rv_cnt, 3);
        chk("bp_rvalid_times", 32'({8'(rv_at[0]), 8'(rv_at[1]), 8'(rv_at[2])}), 32'h04070A);
        chk("bp_data0", 32'(rv_d[0]), 32'h1111);
        chk("bp_data1", 32'(rv_d[1]), 32'h2222);
        chk("bp_data2", 32'(rv_d[2]), 32'h3333);

        // Reset during a write's ACCESS phase
        @(negedge Clk);
        req = 1'b1; req_we = 1'b1; req_addr = 20'h00040; req_wdata = 16'hFFFF; req_be = 2'b11;
        @(negedge Clk);
        req = 1'b0;
        @(negedge Clk);
        chk("rstw_we_low", 32'({CE_N, WE_N}), 32'h0);
        #2 Reset = 1'b0;
        #1;
        chk("rstw_async_strobes", 32'({CE_N, OE_N, WE_N, BE_N}), 32'h1F);
        chk("rstw_flags", 32'({busy, req_ready, wdone}), 32'h0);
        wd = 0;
        repeat (3) begin
            @(negedge Clk);
            if (wdone || rvalid) wd++;
        end
        chk("rstw_addr", 32'(ADDR), 32'h0);
        Reset = 1'b1;
        @(negedge Clk);
        chk("rstw_idle_ready", 32'({req_ready, busy}), 32'h2);
        repeat (5) begin
            @(negedge Clk);
            if (wdone || rvalid) wd++;
        end
        chk("rstw_no_done", wd, 0);
        issue16(1'b0, 20'h00010, 16'h0, 2'b11, lat, rd, oe_lo);
        chk("rstw_recover_read", 32'(rd), 32'h1234);

        // 32-bit port with a single wait state
        issue32(1'b0, 20'h00005, 32'h0, 4'b0101, lat, rd32, ben);
        chk("p32_rd_lat", lat, 3);
        chk("p32_rd_data", rd32, 32'h00B6_0005);
        chk("p32_rd_be_n", 32'(ben), 32'hA);
        issue32(1'b0, 20'h0007E, 32'h0, 4'b1111, lat, rd32, ben);
        chk("p32_rd_full", rd32, 32'hA5B6_C77E);
        issue32(1'b1, 20'h00009, 32'hDEAD_BEEF, 4'b1100, lat, rd32, ben);
        chk("p32_wr_lat", lat, 3);
        chk("p32_wr_be_n", 32'(ben), 32'h3);
        issue32(1'b1, 20'h0000A, 32'h1234_5678, 4'b0000, lat, rd32, ben);
        chk("p32_wr_be0_done", lat, 3);
        chk("p32_wr_be0_be_n", 32'(ben), 32'hF);

        chk("bus_ownership", bus_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
